pic_mailbox_arbiter: RTL and testbench

//  Shares the SPI slave's single PIC-readable byte (Data_ToPic) between N_REQ game-side requesters.

---
 rtl/pic_mailbox_arbiter.sv | 161 ++++++++++++++++
 tb/tb_pic_mailbox_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pic_mailbox_arbiter.sv
// pic_mailbox_arbiter
// Shares the SPI slave's single PIC-readable byte between N_REQ game-side
// requesters. Requests are served round-robin, one 7-bit message at a time,
// each tagged with a toggling sequence bit in bit 7. A message is held in
// Data_ToPic until the PIC echoes that sequence bit back in Data_Status[7],
// or until TIMEOUT_CYC cycles pass without an ack.
//
// Requester handshake: req[i] is the requester's "valid"; it is held high,
// with req_data[7*i+:7] stable, until done[i] pulses for one cycle. done[i]
// is the "ready/complete" strobe: the requester drops req[i] on the edge
// where done[i] is sampled. A req[i] still high when the block is back in
// S_IDLE is treated as a new message. err pulses together with done only
// when the message was abandoned on timeout.

module pic_mailbox_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic                 theClock,
    input  logic                 theReset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [7*N_REQ-1:0]   req_data,
    input  logic [7:0]           Data_Status,
    output logic [7:0]           Data_ToPic,
    output logic [N_REQ-1:0]     done,
    output logic                 err,
    output logic                 busy,
    output logic [7:0]           err_count
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARB      = 3'd1,
        S_POST     = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [IW-1:0]     last;        // most recently granted requester
    logic [IW-1:0]     id;          // requester owning the posted message
    logic [IW-1:0]     grant_idx;
    logic [IW-1:0]     cand;
    logic              grant_found;
    logic              seq;         // sequence bit of the posted message
    logic [CNT_W-1:0]  timer;
    logic              timed_out;
    logic              ack_seen;
    logic              timer_exp;
    logic [6:0]        payload [N_REQ];

    // Only the ack bit of the status byte carries meaning here.
    logic              unused_status;
    assign unused_status = ^Data_Status[6:0];

    assign ack_seen  = (Data_Status[7] == seq);
    assign timer_exp = (timer == CNT_W'(TIMEOUT_CYC - 1));

    // Split the packed payload bus into one 7-bit entry per requester.
    for (genvar g = 0; g < N_REQ; g++) begin : g_payload
        assign payload[g] = req_data[7*g +: 7];
    end

    // Round-robin search starting just after the last grant; scanning from the
    // far end and overwriting leaves the nearest requesting candidate.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % N_REQ);
            if (req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // State register; reset anywhere aborts the message without a done pulse.
    always_ff @(posedge theClock or negedge theReset_n) begin
        if (!theReset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an ack beats a timeout that expires in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (|req) state_nxt = S_ARB;
            S_ARB:      state_nxt = grant_found ? S_POST : S_IDLE;
            S_POST:     state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: if (ack_seen || timer_exp) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers: grant/latch in S_ARB, timer in S_POST/S_WAIT_ACK,
    // error accounting in S_DONE. Data_ToPic changes only on a grant.
    always_ff @(posedge theClock or negedge theReset_n) begin
        if (!theReset_n) begin
            Data_ToPic <= 8'h00;
            seq        <= 1'b0;
            last       <= IW'(N_REQ - 1);
            id         <= '0;
            timer      <= '0;
            timed_out  <= 1'b0;
            err_count  <= 8'h00;
        end else begin
            case (state)
                S_ARB: begin
                    if (grant_found) begin
                        last       <= grant_idx;
                        id         <= grant_idx;
                        seq        <= ~seq;
                        Data_ToPic <= {~seq, payload[grant_idx]};
                    end
                end
                S_POST: begin
                    timer     <= '0;
                    timed_out <= 1'b0;
                end
                S_WAIT_ACK: begin
                    if (ack_seen) begin
                        timed_out <= 1'b0;
                    end else if (timer_exp) begin
                        timed_out <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DONE: begin
                    if (timed_out && (err_count != 8'hFF)) begin
                        err_count <= err_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state: done/err exist only during S_DONE.
    always_comb begin
        done = '0;
        err  = 1'b0;
        busy = (state != S_IDLE);
        if (state == S_DONE) begin
            done[id] = 1'b1;
            err      = timed_out;
        end
    end

endmodule

// File: tb/tb_pic_mailbox_arbiter.sv
// Bench for pic_mailbox_arbiter with a short timeout so error paths are quick.
// The reference model tracks the round-robin pointer, sequence bit and error
// count with plain integers and predicts the done edge from arrival times.

module tb_pic_mailbox_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam int CW = 5;

    logic           theClock   = 1'b0;
    logic           theReset_n = 1'b0;
    logic [N-1:0]   req        = '0;
    logic [7*N-1:0] req_data   = '0;
    logic [7:0]     Data_Status = 8'h00;
    logic [7:0]     Data_ToPic;
    logic [N-1:0]   done;
    logic           err;
    logic           busy;
    logic [7:0]     err_count;

    int             checks   = 0;
    int             failures = 0;

    // reference model state
    int             m_last;
    logic           m_seq;
    int             m_errs;
    logic [N-1:0]   last_done;

    pic_mailbox_arbiter #(
        .N_REQ       (N),
        .TIMEOUT_CYC (TO),
        .CNT_W       (CW)
    ) dut (
        .theClock    (theClock),
        .theReset_n  (theReset_n),
        .req         (req),
        .req_data    (req_data),
        .Data_Status (Data_Status),
        .Data_ToPic  (Data_ToPic),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .err_count   (err_count)
    );

    // clock
    always #5 theClock = ~theClock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] payload_of(input logic [1:0] i);
        logic [27:0] t;
        t = req_data >> (7 * i);
        return t[6:0];
    endfunction

    task automatic reset_dut();
        theReset_n  = 1'b0;
        req         = '0;
        Data_Status = 8'h00;
        repeat (3) @(posedge theClock);
        #1;
        theReset_n  = 1'b1;
        m_last = N - 1;
        m_seq  = 1'b0;
        m_errs = 0;
    endtask

    // One message from an idle start. d >= 0: the PIC acks d cycles after the
    // byte is posted; d = -1: no ack; d = -2: no ack and status forced stale.
    task automatic run_msg(input logic [N-1:0] rq, input int d);
        logic [1:0] c;
        logic [1:0] g;
        logic [7:0] exp_byte;
        logic       exp_err;
        logic [N-1:0] exp_oh;
        int         ack_edge;
        int         exp_edge;
        bit         got;
        g = '0;
        for (int s = N; s >= 1; s--) begin
            c = 2'(m_last + s);
            if (rq[c]) g = c;
        end
        m_last   = int'(g);
        m_seq    = ~m_seq;
        exp_byte = {m_seq, payload_of(g)};
        exp_oh   = 4'b0001 << g;
        Data_Status[6:0] = 7'($urandom);
        if (d == -2) Data_Status[7] = ~m_seq;
        if (Data_Status[7] == m_seq)  ack_edge = 3;
        else if (d >= 0)              ack_edge = (d + 2 > 3) ? d + 2 : 3;
        else                          ack_edge = 1000;
        if (ack_edge <= TO + 2) begin
            exp_edge = ack_edge;
            exp_err  = 1'b0;
        end else begin
            exp_edge = TO + 2;
            exp_err  = 1'b1;
        end
        req = rq;
        got = 1'b0;
        for (int k = 0; k <= TO + 10; k++) begin
            @(posedge theClock);
            #1;
            if (d >= 0 && k == 1 + d) Data_Status[7] = m_seq;
            if (k == 1) begin
                chk("posted_byte", 32'(Data_ToPic), 32'(exp_byte));
                chk("busy_high", 32'(busy), 32'd1);
                req_data = req_data ^ (28'h7F << (7 * g));
            end
            if (done != '0) begin
                got       = 1'b1;
                last_done = done;
                chk("done_edge", 32'(k), 32'(exp_edge));
                chk("done_onehot", 32'(done), 32'(exp_oh));
                chk("err_flag", 32'(err), 32'(exp_err));
                chk("byte_at_done", 32'(Data_ToPic), 32'(exp_byte));
                req[g] = 1'b0;
                break;
            end
        end
        if (!got) chk("done_seen", 32'd0, 32'd1);
        if (exp_err && m_errs < 255) m_errs++;
        @(posedge theClock);
        #1;
        req = '0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_err", 32'(err), 32'd0);
        chk("err_count", 32'(err_count), 32'(m_errs));
        chk("byte_held", 32'(Data_ToPic), 32'(exp_byte));
    endtask

    int order_tab [5] = '{0, 1, 2, 3, 0};
    logic seq_tab [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        // reset values while reset is asserted
        #1;
        chk("rst_byte", 32'(Data_ToPic), 32'h00);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);

        // single requester, ack five cycles after posting
        reset_dut();
        req_data = '0;
        req_data[6:0] = 7'h15;
        run_msg(4'b0001, 5);
        chk("t1_byte", 32'(Data_ToPic), 32'h95);

        // all requesters held: rotation and alternating sequence bit
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            req_data = 28'($urandom);
            run_msg(4'b1111, $urandom_range(0, 4));
            chk("t2_grant", 32'(last_done), 32'(4'b0001 << order_tab[i]));
            chk("t2_seq", 32'(Data_ToPic[7]), 32'(seq_tab[i]));
        end

        // timeout, then the next message toggles seq again
        reset_dut();
        req_data = 28'($urandom);
        run_msg(4'b0010, -1);
        chk("t3_errcnt", 32'(err_count), 32'd1);
        run_msg(4'b0010, 2);
        chk("t3_next_seq", 32'(Data_ToPic[7]), 32'd0);

        // status already matching the upcoming seq: done three edges after ARB
        Data_Status = 8'h80;
        run_msg(4'b0001, -1);

        // reset while waiting for an ack
        reset_dut();
        req = 4'b0100;
        repeat (4) @(posedge theClock);
        #1;
        chk("t5_no_done", 32'(done), 32'd0);
        chk("t5_busy", 32'(busy), 32'd1);
        theReset_n = 1'b0;
        #1;
        chk("t5_byte", 32'(Data_ToPic), 32'h00);
        chk("t5_busy_rst", 32'(busy), 32'd0);
        chk("t5_done_rst", 32'(done), 32'd0);
        req = '0;
        repeat (2) @(posedge theClock);
        #1;
        theReset_n = 1'b1;
        m_last = N - 1;
        m_seq  = 1'b0;
        m_errs = 0;
        run_msg(4'b1111, 1);
        chk("t5_first_grant", 32'(last_done), 32'd1);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            req_data = 28'($urandom);
            run_msg(4'($urandom_range(1, 15)), int'($urandom_range(0, 23)) - 2);
        end

        // saturation of the timeout counter
        reset_dut();
        for (int i = 0; i < 260; i++) begin
            req_data = 28'($urandom);
            run_msg(4'($urandom_range(1, 15)), -2);
        end
        chk("t6_saturated", 32'(err_count), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
